// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the RISC-V core.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    // Force a target address onto a 4-byte instruction boundary.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // True when a target address is not on a 4-byte boundary.
    function automatic logic pc_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage : riscv_pkg

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned IW = PW - 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    fetch_entry_t  r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    // A pop only happens with data present; a push into a full FIFO is only
    // legal when the head leaves in the same cycle (pop-then-push).
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);

    // Pointer update; a flush discards every entry, including one being popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Entry storage; when full with a simultaneous pop, the slot written is
    // the head being read out this cycle, which is already consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr[IW-1:0]] <= i_data;
        end
    end

    // Head entry; forced to zero while empty so decode never sees stale data.
    always_comb begin
        o_data = '0;
        if (o_empty) begin
            o_data = '0;
        end else begin
            o_data = r_mem[r_rd_ptr[IW-1:0]];
        end
    end

endmodule : fetch_fifo

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the combinational instruction memory,
// buffers {pc, instr} in a FIFO and hands entries to decode over valid/ready.
// Redirects from execute flush the buffer and reload the PC.
// XLEN must match the package XLEN because the buffered entry type uses it.
module instr_fetch #(
    parameter int unsigned       XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_instruction,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            misalign_err,
    output logic [31:0]     fetch_count
);

    import riscv_pkg::*;

    logic [XLEN-1:0] r_pc;
    logic            r_misalign_err;
    logic [31:0]     r_fetch_count;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    fetch_entry_t    w_wr_entry;
    fetch_entry_t    w_head;

    // Memory answers in the same cycle, so the PC register addresses it directly.
    assign imem_addr = r_pc;

    // Handshake: decode consumes the head; fetch pushes whenever a slot is
    // free (or frees this cycle) and no redirect is in flight.
    assign w_pop  = out_valid & out_ready;
    assign w_push = ~redirect_valid & (~w_full | w_pop);

    // Pack the current fetch result for the FIFO tail.
    always_comb begin
        w_wr_entry       = '0;
        w_wr_entry.pc    = r_pc;
        w_wr_entry.instr = imem_instruction;
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_wr_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid    = ~w_empty;
    assign out_pc       = w_head.pc;
    assign out_instr    = w_head.instr;
    assign misalign_err = r_misalign_err;
    assign fetch_count  = r_fetch_count;

    // PC register: redirect wins, otherwise step past each pushed instruction
    // (wraps modulo 2^XLEN), otherwise hold while the buffer is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= pc_align(redirect_pc);
        end else if (w_push) begin
            r_pc <= r_pc + XLEN'(PC_STEP);
        end else begin
            r_pc <= r_pc;
        end
    end

    // One-cycle flag for a redirect target that is not word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            r_misalign_err <= pc_misaligned(redirect_pc);
        end else begin
            r_misalign_err <= 1'b0;
        end
    end

    // Performance counter of pushed instructions; survives redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 32'd0;
        end else if (w_push) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a scoreboard queue is loaded with the
// expected {pc, instr} stream whenever the PC is (re)started, and every
// accepted output entry is popped from it and compared.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int          n_checks;
    int          n_errors;
    logic [63:0] sb_q [$];

    instr_fetch #(
        .XLEN             (32),
        .RESET_PC         (32'h0000_0000),
        .FIFO_DEPTH       (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .misalign_err     (misalign_err),
        .fetch_count      (fetch_count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: four program words, a recognisable
    // address-derived pattern elsewhere.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h0050_0093;
            32'd4:   return 32'h0030_0113;
            32'd8:   return 32'h0020_81B3;
            32'd12:  return 32'h4020_8233;
            default: return a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    // Combinational instruction memory.
    always_comb imem_instruction = mem_model(imem_addr);

    // Count a comparison and report a mismatch.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reload the scoreboard with the sequential stream starting at start_pc.
    task automatic sb_fill(input logic [31:0] start_pc);
        logic [31:0] p;
        sb_q.delete();
        p = start_pc;
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back({p, mem_model(p)});
            p = p + 32'd4;
        end
    endtask

    // Advance n clock cycles and settle just after the edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle redirect and check the two-cycle refill behaviour.
    task automatic do_redirect(input logic [31:0] tgt, input string tag);
        logic [31:0] aligned;
        logic        exp_mis;
        aligned = {tgt[31:2], 2'b00};
        exp_mis = (tgt[1:0] != 2'b00);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        wait_cycles(1);
        redirect_valid = 1'b0;
        sb_fill(aligned);
        check({tag, "_valid_flushed"}, 64'(out_valid), 64'd0);
        check({tag, "_imem_addr"}, 64'(imem_addr), 64'(aligned));
        check({tag, "_misalign"}, 64'(misalign_err), 64'(exp_mis));
        wait_cycles(1);
        check({tag, "_misalign_clear"}, 64'(misalign_err), 64'd0);
        check({tag, "_valid_refill"}, 64'(out_valid), 64'd1);
        check({tag, "_first_pc"}, 64'(out_pc), 64'(aligned));
    endtask

    // Scoreboard monitor: compare each accepted entry with the expected stream.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("sb_pc", 64'(out_pc), 64'(e[63:32]));
                check("sb_instr", 64'(out_instr), 64'(e[31:0]));
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b1;
        sb_fill(32'd0);
        wait_cycles(2);

        // Reset state.
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_pc_out", 64'(out_pc), 64'd0);
        check("rst_instr_out", 64'(out_instr), 64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);
        check("rst_count", 64'(fetch_count), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);

        // Streaming with decode always ready.
        rst_n = 1'b1;
        wait_cycles(1);
        check("stream_valid_1cyc", 64'(out_valid), 64'd1);
        check("stream_first_pc", 64'(out_pc), 64'd0);
        wait_cycles(3);
        check("stream_count4", 64'(fetch_count), 64'd4);
        check("stream_pc12", 64'(out_pc), 64'd12);
        check("stream_pops", 64'(sb_q.size()), 64'd5);

        // Backpressure from reset release.
        rst_n     = 1'b0;
        out_ready = 1'b0;
        #1;
        sb_fill(32'd0);
        wait_cycles(1);
        rst_n = 1'b1;
        wait_cycles(5);
        check("bp_imem_hold", 64'(imem_addr), 64'd8);
        check("bp_out_pc_hold", 64'(out_pc), 64'd0);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_count", 64'(fetch_count), 64'd2);
        out_ready = 1'b1;
        wait_cycles(3);
        check("bp_release_pops", 64'(sb_q.size()), 64'd5);
        check("bp_release_head", 64'(out_pc), 64'd12);

        // Redirect while two entries are buffered.
        out_ready = 1'b0;
        wait_cycles(2);
        do_redirect(32'h0000_0040, "redir40");
        out_ready = 1'b1;
        wait_cycles(3);
        check("redir40_pops", 64'(sb_q.size()), 64'd5);

        // Misaligned redirect target, decode ready throughout.
        do_redirect(32'h0000_0042, "redir42");
        wait_cycles(2);
        check("redir42_pops", 64'(sb_q.size()), 64'd6);

        // Redirect to the top of the address space: PC wraps to zero.
        do_redirect(32'hFFFF_FFFC, "redirtop");
        wait_cycles(2);
        check("wrap_pops", 64'(sb_q.size()), 64'd6);
        check("wrap_head", 64'(out_pc), 64'd4);

        // Asynchronous reset mid-stream while full.
        out_ready = 1'b0;
        wait_cycles(3);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(fetch_count), 64'd0);
        check("midrst_imem_addr", 64'(imem_addr), 64'd0);
        sb_fill(32'd0);
        wait_cycles(1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        wait_cycles(4);
        check("midrst_restart_count", 64'(fetch_count), 64'd4);
        check("midrst_restart_pops", 64'(sb_q.size()), 64'd5);
        check("midrst_restart_head", 64'(out_pc), 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch-side initiator for the combinational instruction memory `instr_mem`. It owns the program counter and drives `imem_addr` each cycle. It captures the returned `imem_instruction` together with its PC into a small FIFO, and presents {pc, instr} to decode over a valid/ready handshake. It sits between `instr_mem` and the decode stage of the RISC-V core and accepts branch/jump redirects from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FIFO_DEPTH, 2, number of fetched {pc, instr} entries buffered; power of two, minimum 2
XLEN, 32, address/instruction width

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  XLEN  byte address to `instr_mem`; equals the PC register
imem_instruction  input  32  instruction word returned combinationally by `instr_mem` for `imem_addr`
redirect_valid  input  1  one-cycle request to change the PC
redirect_pc  input  XLEN  target PC for the redirect
out_valid  output  1  head entry valid toward decode
out_ready  input  1  decode accepts the head entry
out_instr  output  32  instruction at the FIFO head
out_pc  output  XLEN  PC of the FIFO head instruction
misalign_err  output  1  one-cycle pulse when `redirect_pc[1:0]` != 0
fetch_count  output  32  number of instructions pushed into the FIFO since reset (performance counter)

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - pc = RESET_PC; FIFO empty; out_valid = 0; misalign_err = 0; fetch_count = 0.
  - out_instr and out_pc = 0 while empty.
- `imem_addr` = pc register, combinational. The memory returns in the same cycle, so fetch latency is 0 cycles. The first instruction is visible on `out_*` one cycle after reset release.
- pop = out_valid & out_ready.
- push = !redirect_valid & (!full | pop). When full, a same-cycle pop frees the slot: pop-then-push, so full throughput is sustained.
- On push:
  - write {pc, imem_instruction} at the tail.
  - pc <= pc + 4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
  - fetch_count <= fetch_count + 1, wrapping.
- redirect_valid has priority over everything:
  - flush the FIFO, so out_valid = 0 next cycle and any entry being popped in the same cycle is still considered consumed.
  - no push that cycle.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - misalign_err <= (redirect_pc[1:0] != 0) for exactly one cycle.
- After a redirect, the first fetched instruction appears on the outputs two cycles after the redirect cycle: one cycle to load the PC, one cycle to push.
- out_valid & !out_ready: out_instr and out_pc must hold stable; the PC does not advance once the FIFO is full.
- Empty FIFO: out_valid = 0. No pop is possible, and out_ready is ignored.
- fetch_count is not cleared by redirect.
- Reset asserted mid-operation: immediate return to reset values regardless of handshake state.

Decomposition:
- Shared package `riscv_pkg`:
  - XLEN = 32
  - PC_STEP = 4
  - INSTR_NOP = 32'h0000_0013
  - typedef `fetch_entry_t` = {pc[XLEN-1:0], instr[31:0]}
- One sub-module: `fetch_fifo`, a parameterised synchronous FIFO.
  - Ports: push, pop, flush, full, empty, data in/out.
  - Async active-low reset; pointer width = $clog2(FIFO_DEPTH)+1.
- `instr_fetch` holds the PC, redirect logic, error pulse, and counter.

Test Plan:
- Reset release with `instr_mem` loaded with 0x00500093, 0x00300113, 0x002081B3, 0x40208233, and out_ready = 1 -> out_valid rises 1 cycle after reset release, and outputs (pc, instr) are:
  - (0, 00500093)
  - (4, 00300113)
  - (8, 002081B3)
  - (12, 40208233)
  - on consecutive cycles; fetch_count = 4 after the 4th push.
- Backpressure with out_ready = 0 for 5 cycles after reset release -> FIFO fills with pc 0 and 4, imem_addr holds at 8, out_pc stays 0. Releasing out_ready -> pcs 0, 4, 8 are delivered on consecutive cycles with no loss or duplication.
- redirect_valid = 1 with redirect_pc = 0x40 while 2 entries are buffered -> out_valid = 0 next cycle, imem_addr = 0x40, then out_pc = 0x40 two cycles after the redirect, with no stale entries.
- redirect_pc = 0x42 -> misalign_err high for exactly 1 cycle, imem_addr = 0x40.
- Redirect to 0xFFFF_FFFC -> outputs pc 0xFFFF_FFFC, then pc 0x0000_0000.
- rst_n pulsed low mid-stream while full -> out_valid = 0 and fetch_count = 0 immediately (asynchronous), and imem_addr = RESET_PC. The sequence restarts at pc 0 after release.
